instr_loader: RTL

Byte-stream program loader feeding the instruction memory write port (we/addr/dout, byte address, one 32-bit word per write). Consumes bytes from the UART receiver, assembles little-endian 32-bit words and writes them to consecutive word addresses starting at ADDR_BASE. Raises `done` when the image is in memory so the top level can release the core. Replaces fixed-table instruction generation with a host-supplied program image.

---
 rtl/instr_loader_if.sv | 13 +
 rtl/instr_loader.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/instr_loader_if.sv
// Byte-stream in / instruction-memory write out bundle for the program loader.
interface instr_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        we;
    logic [31:0] addr;
    logic [31:0] dout;

    // master: UART/host side feeding bytes and watching the memory writes
    modport master (output rx_valid, output rx_data, input we, input addr, input dout);
    // slave: the loader itself
    modport slave  (input rx_valid, input rx_data, output we, output addr, output dout);
endinterface

// File: rtl/instr_loader.sv
// Program image loader: little-endian word count, then words written to instruction memory.
// Optional trailing checksum byte enabled with `define LOADER_CHECKSUM_EN.
//
// state  | meaning
// S_LEN  | collecting the 4 word-count bytes
// S_DATA | assembling and writing data words
// S_CHK  | waiting for checksum byte (LOADER_CHECKSUM_EN only)
// S_DONE | image in memory, held until restart
// S_ERR  | load failed, held until restart
module instr_loader #(
    parameter logic [31:0] ADDR_BASE = 32'h0,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              restart,
    instr_loader_if.slave     bus,
    output logic              loading,
    output logic              done,
    output logic              err
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_LEN, S_DATA, S_CHK, S_DONE, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_LEN, S_DATA, S_DONE, S_ERR} state_t;
`endif

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [23:0] asm_buf;
    logic [31:0] word_idx;
    logic [31:0] words_left;
    logic [31:0] asm_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    // Bytes shift in from the top, so after three bytes asm_buf = {b2,b1,b0}.
    assign asm_word = {bus.rx_data, asm_buf};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_LEN;
            byte_cnt   <= 2'd0;
            asm_buf    <= '0;
            word_idx   <= '0;
            words_left <= '0;
            bus.we     <= 1'b0;
            bus.addr   <= ADDR_BASE;
            bus.dout   <= '0;
            loading    <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            bus.we <= 1'b0;
            case (state)
                S_LEN: begin
                    if (bus.rx_valid) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        asm_buf  <= {bus.rx_data, asm_buf[23:8]};
                        if (byte_cnt == 2'd3) begin
                            asm_buf <= '0;
                            if (asm_word == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                                state   <= S_CHK;
`else
                                state   <= S_DONE;
                                done    <= 1'b1;
                                loading <= 1'b0;
`endif
                            end else if (asm_word > MAX_WORDS) begin
                                state   <= S_ERR;
                                err     <= 1'b1;
                                loading <= 1'b0;
                            end else begin
                                state      <= S_DATA;
                                word_idx   <= '0;
                                words_left <= asm_word;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (bus.rx_valid) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        asm_buf  <= {bus.rx_data, asm_buf[23:8]};
`ifdef LOADER_CHECKSUM_EN
                        csum     <= csum + bus.rx_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            asm_buf    <= '0;
                            bus.we     <= 1'b1;
                            bus.addr   <= ADDR_BASE + (word_idx << 2);
                            bus.dout   <= asm_word;
                            word_idx   <= word_idx + 32'd1;
                            words_left <= words_left - 32'd1;
                            if (words_left == 32'd1) begin
`ifdef LOADER_CHECKSUM_EN
                                state   <= S_CHK;
`else
                                state   <= S_DONE;
                                done    <= 1'b1;
                                loading <= 1'b0;
`endif
                            end
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (bus.rx_valid) begin
                        loading <= 1'b0;
                        if (bus.rx_data == csum) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE, S_ERR: begin
                    // Incoming bytes are dropped here; only restart leaves these states.
                    if (restart) begin
                        state      <= S_LEN;
                        byte_cnt   <= 2'd0;
                        asm_buf    <= '0;
                        word_idx   <= '0;
                        words_left <= '0;
                        loading    <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        csum       <= '0;
`endif
                    end
                end
                default: begin
                    state <= S_LEN;
                end
            endcase
        end
    end

endmodule
